// File: rtl/led_matrix_pkg.sv
// Shared geometry, colour-bit positions and pixel/column types for the 8x8 RGB matrix.
package led_matrix_pkg;

  localparam int MATRIX_COLS = 8;
  localparam int MATRIX_ROWS = 8;

  // Bit positions inside a pixel_t, {R,G,B}.
  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

  typedef logic [2:0] pixel_t;
  typedef pixel_t [MATRIX_ROWS-1:0] column_t;
  typedef logic [$clog2(MATRIX_COLS)-1:0] col_idx_t;

  // Active-low pin image of one colour plane of a column; pin j drives row j.
  function automatic logic [0:MATRIX_ROWS-1] col_drive(input column_t col, input logic [1:0] color);
    logic [0:MATRIX_ROWS-1] drv;
    for (int j = 0; j < MATRIX_ROWS; j++) begin
      drv[j] = ~col[j][color];
    end
    return drv;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_tick.sv
// scan_tick_gen: free-running 0..CLK_DIV-1 divider producing a one-cycle tick on its
// last count. Shared by the column scan and the game-clock path.
module scan_tick_gen
  import led_matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count and wrap back to zero in the same edge.
  // NOTE: combinational logic uses blocking '='; the register below uses '<=' so every
  // flop samples pre-edge values.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 RGB framebuffer with column-multiplexed,
// active-low LED drive. Game logic writes/clears the back buffer and requests a swap;
// the swap happens at the next frame boundary (tick with comm == 7).
// Optional macro SCAN_BLANK_EN: forces LedR/G/B off for BLANK_CYC cycles after each
// column change (anti-ghosting). Undefined: column data shows for the whole dwell.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clr,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       swap_ack,
  output logic [2:0] comm,
  output logic       enable,
  output logic [0:7] LedR,
  output logic [0:7] LedG,
  output logic [0:7] LedB
);

  localparam col_idx_t COL_LAST = col_idx_t'(MATRIX_COLS - 1);

  logic tick;

  column_t  fb_q [2][MATRIX_COLS];
  column_t  fb_d [2][MATRIX_COLS];
  logic     front_sel_q, front_sel_d;
  logic     back_sel;
  logic     swap_pending_q, swap_pending_d;
  logic     swap_ack_q, swap_ack_d;
  logic     enable_q, enable_d;
  col_idx_t comm_q, comm_d;
  logic [0:MATRIX_ROWS-1] led_r_q, led_r_d;
  logic [0:MATRIX_ROWS-1] led_g_q, led_g_d;
  logic [0:MATRIX_ROWS-1] led_b_q, led_b_d;
  logic     frame_end, swap_now;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (SYS_CLK),
    .rst  (RST),
    .tick (tick)
  );

  // Back-buffer writes, swap control and next column load.
  // NOTE: every variable gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    fb_d           = fb_q;
    comm_d         = comm_q;
    enable_d       = enable_q;
    led_r_d        = led_r_q;
    led_g_d        = led_g_q;
    led_b_d        = led_b_q;

    // Writes target the back buffer as selected at the start of this cycle;
    // a clear lands first so a same-cycle write survives it.
    back_sel = ~front_sel_q;
    if (clr)   fb_d[back_sel] = '{default: '0};
    if (wr_en) fb_d[back_sel][wr_x][wr_y] = wr_rgb;

    frame_end      = tick && (comm_q == COL_LAST);
    swap_now       = frame_end && swap_pending_q;
    front_sel_d    = front_sel_q ^ swap_now;
    // A request arriving in the swap cycle is absorbed by that swap.
    swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | swap_req);
    swap_ack_d     = swap_now;

    if (tick) begin
      comm_d   = comm_q + 1'b1;
      enable_d = 1'b1;
      // Load from the post-swap front so the pins always match comm.
      led_r_d  = col_drive(fb_d[front_sel_d][comm_d], 2'(RGB_R));
      led_g_d  = col_drive(fb_d[front_sel_d][comm_d], 2'(RGB_G));
      led_b_d  = col_drive(fb_d[front_sel_d][comm_d], 2'(RGB_B));
    end
  end

  // State registers; reset clears both buffers and returns the pins to all-off.
  // NOTE: the frame buffers are flops, not RAM, because reset must clear both of them.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      fb_q           <= '{default: '0};
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
      enable_q       <= 1'b0;
      comm_q         <= '0;
      led_r_q        <= '1;
      led_g_q        <= '1;
      led_b_q        <= '1;
    end else begin
      fb_q           <= fb_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      swap_ack_q     <= swap_ack_d;
      enable_q       <= enable_d;
      comm_q         <= comm_d;
      led_r_q        <= led_r_d;
      led_g_q        <= led_g_d;
      led_b_q        <= led_b_d;
    end
  end

  assign swap_pending = swap_pending_q;
  assign swap_ack     = swap_ack_q;
  assign comm         = comm_q;
  assign enable       = enable_q;

`ifdef SCAN_BLANK_EN
  localparam int unsigned BLK_W = $clog2(BLANK_CYC + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC);

  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic             blank;

  // Count cycles since the last column change, saturating at BLANK_CYC.
  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (tick)                         blank_cnt_d = '0;
    else if (blank_cnt_q != BLK_LAST) blank_cnt_d = blank_cnt_q + 1'b1;
    blank = (blank_cnt_q != BLK_LAST);
  end

  // Blanking counter register; out of reset it sits idle at the saturated count.
  always_ff @(posedge SYS_CLK) begin
    if (RST) blank_cnt_q <= BLK_LAST;
    else     blank_cnt_q <= blank_cnt_d;
  end

  assign LedR = led_r_q | {MATRIX_ROWS{blank}};
  assign LedG = led_g_q | {MATRIX_ROWS{blank}};
  assign LedB = led_b_q | {MATRIX_ROWS{blank}};
`else
  // Column data drives the pins for the whole dwell; BLANK_CYC has no effect here.
  if (BLANK_CYC >= CLK_DIV) begin : g_blank_unused
  end

  assign LedR = led_r_q;
  assign LedG = led_g_q;
  assign LedB = led_b_q;
`endif

endmodule
